// File: rtl/control_unit.sv
// control_unit: WF8 multi-cycle fetch/decode/execute sequencer.
// Optional feature macro: ILLEGAL_TRAP_EN (opcodes A-D halt and flag illegal).
`ifndef ALU_MODE_COUNT
  `define ALU_MODE_COUNT 7
`endif
`ifndef ALU_FLAG_COUNT
  `define ALU_FLAG_COUNT 4
`endif
`ifndef ALU_FLAG_ZERO
  `define ALU_FLAG_ZERO 0
`endif

module control_unit #(
  parameter int BIT_COUNT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req,
  input  logic                       imem_valid,
  input  logic [7:0]                 imem_data,
  input  logic [`ALU_FLAG_COUNT-1:0] alu_flags,
  output logic [`ALU_MODE_COUNT-1:0] alu_mode,
  output logic                       alu_a_sel,
  output logic                       alu_b_sel,
  output logic [2:0]                 reg_sel,
  output logic [BIT_COUNT-1:0]       imm_out,
  output logic                       acc_we,
  output logic                       reg_we,
  output logic                       pc_inc,
  output logic                       pc_we,
  output logic                       halted,
  output logic                       illegal
);

  localparam int MW    = `ALU_MODE_COUNT;
  localparam int M_ADD = 0;
  localparam int M_SH  = 1;
  localparam int M_NOT = 2;
  localparam int M_AND = 3;
  localparam int M_OR  = 4;
  localparam int M_BYA = 5;
  localparam int M_BYB = 6;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           insn_q, insn_d;
  logic                 zflag_q, zflag_d;
  logic                 req_q, req_d;
  logic [MW-1:0]        mode_q, mode_d;
  logic                 a_sel_q, a_sel_d;
  logic                 b_sel_q, b_sel_d;
  logic [2:0]           rsel_q, rsel_d;
  logic [BIT_COUNT-1:0] imm_q, imm_d;
  logic                 acc_we_q, acc_we_d;
  logic                 reg_we_q, reg_we_d;
  logic                 pc_we_q, pc_we_d;
  logic                 halted_q, halted_d;
  logic                 illegal_q, illegal_d;

  logic [3:0] op;
  logic       alu_op;
  logic       trap;
  logic       unused_flags;

  assign op           = insn_q[7:4];
  assign alu_op       = (op <= 4'h6);
  assign unused_flags = ^alu_flags;

`ifdef ILLEGAL_TRAP_EN
  assign trap = (op >= 4'hA) && (op <= 4'hD);
`else
  assign trap = 1'b0;
`endif

  // Next-state and next-output decode; EXECUTE strobes default low.
  always_comb begin
    state_d   = state_q;
    insn_d    = insn_q;
    zflag_d   = zflag_q;
    rsel_d    = rsel_q;
    imm_d     = imm_q;
    a_sel_d   = a_sel_q;
    b_sel_d   = b_sel_q;
    mode_d    = '0;
    acc_we_d  = 1'b0;
    reg_we_d  = 1'b0;
    pc_we_d   = 1'b0;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_FETCH: begin
        if (req_q && imem_valid) begin
          insn_d  = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        rsel_d  = insn_q[2:0];
        imm_d   = {{(BIT_COUNT-4){insn_q[3]}}, insn_q[3:0]};
        a_sel_d = (op == 4'h9);
        b_sel_d = (op == 4'h1) || (op == 4'h3) || (op == 4'h9);
        state_d = S_EXEC;
        unique case (op)
          4'h0, 4'h1: begin
            mode_d[M_ADD] = 1'b1;
            acc_we_d      = 1'b1;
          end
          4'h2, 4'h3: begin
            mode_d[M_SH] = 1'b1;
            acc_we_d     = 1'b1;
          end
          4'h4: begin
            mode_d[M_NOT] = 1'b1;
            acc_we_d      = 1'b1;
          end
          4'h5: begin
            mode_d[M_AND] = 1'b1;
            acc_we_d      = 1'b1;
          end
          4'h6: begin
            mode_d[M_OR] = 1'b1;
            acc_we_d     = 1'b1;
          end
          4'h7: begin
            mode_d[M_BYA] = 1'b1;
            reg_we_d      = 1'b1;
          end
          4'h8: begin
            mode_d[M_BYB] = 1'b1;
            acc_we_d      = 1'b1;
          end
          4'h9: begin
            mode_d[M_ADD] = 1'b1;
            pc_we_d       = zflag_q;
          end
          4'hF: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
          default: begin
            if (trap) begin
              state_d   = S_HALT;
              halted_d  = 1'b1;
              illegal_d = 1'b1;
            end
          end
        endcase
      end
      S_EXEC: begin
        if (alu_op) zflag_d = alu_flags[`ALU_FLAG_ZERO];
        state_d = S_FETCH;
      end
      default: begin
      end
    endcase
    req_d = (state_d == S_FETCH);
  end

  // Single register bank for FSM state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      insn_q    <= 8'hE0;
      zflag_q   <= 1'b0;
      req_q     <= 1'b0;
      mode_q    <= '0;
      a_sel_q   <= 1'b0;
      b_sel_q   <= 1'b0;
      rsel_q    <= 3'd0;
      imm_q     <= '0;
      acc_we_q  <= 1'b0;
      reg_we_q  <= 1'b0;
      pc_we_q   <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      insn_q    <= insn_d;
      zflag_q   <= zflag_d;
      req_q     <= req_d;
      mode_q    <= mode_d;
      a_sel_q   <= a_sel_d;
      b_sel_q   <= b_sel_d;
      rsel_q    <= rsel_d;
      imm_q     <= imm_d;
      acc_we_q  <= acc_we_d;
      reg_we_q  <= reg_we_d;
      pc_we_q   <= pc_we_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_req  = req_q;
  assign pc_inc    = (state_q == S_FETCH) && req_q && imem_valid;
  assign alu_mode  = mode_q;
  assign alu_a_sel = a_sel_q;
  assign alu_b_sel = b_sel_q;
  assign reg_sel   = rsel_q;
  assign imm_out   = imm_q;
  assign acc_we    = acc_we_q;
  assign reg_we    = reg_we_q;
  assign pc_we     = pc_we_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction stream against an
// instruction-level reference model of the WF8 sequencer.
`ifndef ALU_MODE_COUNT
  `define ALU_MODE_COUNT 7
`endif
`ifndef ALU_FLAG_COUNT
  `define ALU_FLAG_COUNT 4
`endif
`ifndef ALU_FLAG_ZERO
  `define ALU_FLAG_ZERO 0
`endif

module tb_control_unit;

  localparam int BW = 8;
  localparam int MW = `ALU_MODE_COUNT;
  localparam int FW = `ALU_FLAG_COUNT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          imem_req;
  logic          imem_valid = 1'b0;
  logic [7:0]    imem_data = 8'h00;
  logic [FW-1:0] alu_flags = '0;
  logic [MW-1:0] alu_mode;
  logic          alu_a_sel, alu_b_sel;
  logic [2:0]    reg_sel;
  logic [BW-1:0] imm_out;
  logic          acc_we, reg_we, pc_inc, pc_we;
  logic          halted, illegal;

  control_unit #(.BIT_COUNT(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_valid(imem_valid),
    .imem_data(imem_data), .alu_flags(alu_flags),
    .alu_mode(alu_mode), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .reg_sel(reg_sel),
    .imm_out(imm_out), .acc_we(acc_we),
    .reg_we(reg_we), .pc_inc(pc_inc),
    .pc_we(pc_we), .halted(halted),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  bit mz = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: ALU mode bit for an opcode, -1 if no ALU op issued.
  function automatic int mode_bit(input int op);
    case (op)
      0, 1, 9: return 0;
      2, 3:    return 1;
      4:       return 2;
      5:       return 3;
      6:       return 4;
      7:       return 5;
      8:       return 6;
      default: return -1;
    endcase
  endfunction

  function automatic bit traps(input int op);
`ifdef ILLEGAL_TRAP_EN
    return op >= 10 && op <= 13;
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_valid = 1'b0;
    #1;
    chk("rst_outs", {imem_req, pc_inc, alu_mode, alu_a_sel,
                     alu_b_sel, reg_sel, imm_out, acc_we,
                     reg_we, pc_we, halted, illegal}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_req0", imem_req, 0);
    mz = 1'b0;
  endtask

  task automatic run_insn(input logic [7:0] insn,
                          input int wait_n,
                          input bit z);
    int op;
    int mb;
    int pcs;
    int sx;
    bit ill;
    op  = int'(insn[7:4]);
    pcs = 0;
    ill = traps(op);
    for (int i = 0; i <= wait_n; i++) begin
      @(negedge clk);
      imem_valid = (i == wait_n);
      imem_data  = (i == wait_n) ? insn : 8'($urandom);
      alu_flags  = FW'($urandom);
      #1;
      chk("f_req", imem_req, 1);
      chk("f_pcinc", pc_inc, (i == wait_n) ? 1 : 0);
      chk("f_mode", alu_mode, 0);
      chk("f_halt", halted, 0);
      pcs += int'(pc_inc);
    end
    chk("pcinc_cnt", pcs, 1);
    @(negedge clk);
    imem_valid = 1'($urandom);
    imem_data  = 8'($urandom);
    #1;
    chk("d_req", imem_req, 0);
    chk("d_pcinc", pc_inc, 0);
    chk("d_mode", alu_mode, 0);
    chk("d_we", {acc_we, reg_we, pc_we}, 0);
    if (op == 15 || ill) begin
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        imem_valid = 1'($urandom);
        #1;
        chk("h_halted", halted, 1);
        chk("h_illegal", illegal, ill ? 1 : 0);
        chk("h_req", imem_req, 0);
        chk("h_outs", {alu_mode, acc_we, reg_we, pc_we, pc_inc}, 0);
      end
      do_reset();
      return;
    end
    @(negedge clk);
    imem_valid = 1'($urandom);
    alu_flags  = FW'($urandom);
    alu_flags[`ALU_FLAG_ZERO] = z;
    #1;
    mb = mode_bit(op);
    sx = int'(insn[3:0]);
    if (sx > 7) sx -= 16;
    chk("x_mode", alu_mode, (mb < 0) ? 0 : (32'd1 << mb));
    chk("x_rsel", reg_sel, insn & 8'h07);
    chk("x_imm", imm_out, sx & 32'hFF);
    if (op <= 9) begin
      chk("x_asel", alu_a_sel, (op == 9) ? 1 : 0);
      chk("x_bsel", alu_b_sel,
          (op == 1 || op == 3 || op == 9) ? 1 : 0);
    end
    chk("x_accwe", acc_we, (op <= 6 || op == 8) ? 1 : 0);
    chk("x_regwe", reg_we, (op == 7) ? 1 : 0);
    chk("x_pcwe", pc_we, (op == 9 && mz) ? 1 : 0);
    chk("x_req", imem_req, 0);
    chk("x_flags", {halted, illegal, pc_inc}, 0);
    if (op <= 6) mz = z;
  endtask

  logic [7:0] d_insn[$];
  int         d_wait[$];
  bit         d_z[$];

  initial begin
    d_insn = '{8'h15, 8'h00, 8'h9E, 8'h00, 8'h9E, 8'h00,
               8'h73, 8'h9E, 8'h15, 8'hA0, 8'h40, 8'hF0,
               8'h15};
    d_wait = '{0, 0, 0, 1, 0, 0, 2, 0, 4, 0, 0, 1, 0};
    d_z    = '{0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0};
    do_reset();
    foreach (d_insn[k]) run_insn(d_insn[k], d_wait[k], d_z[k]);
    for (int n = 0; n < 250; n++) begin
      logic [7:0] ins;
      ins = 8'($urandom);
      if (ins[7:4] == 4'hF && $urandom_range(0, 5) != 0)
        ins[7:4] = 4'hE;
      run_insn(ins, $urandom_range(0, 3),
               1'($urandom_range(0, 1)));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
